// File: rtl/fb_pingpong_pkg.sv
// Shared panel geometry (128x48) for the frame store and led_matrix,
// plus the read-side swap state type.
package fb_pingpong_pkg;

    localparam int FB_ADDR_WIDTH  = 13;
    localparam int FB_DATA_WIDTH  = 8;
    localparam int FB_NUM_WORDS   = 128 * 48;
    localparam int FB_SYNC_STAGES = 2;

    typedef enum logic [0:0] {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_e;

endpackage

// File: rtl/fb_bank.sv
// One framebuffer bank: registered read in the display domain, write port in
// the writer domain that discards out-of-range addresses.
module fb_bank
    import fb_pingpong_pkg::*;
#(
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int DATA_WIDTH = FB_DATA_WIDTH,
    parameter int NUM_WORDS  = FB_NUM_WORDS
) (
    input  logic                  rd_clk_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  wr_clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Registered read; addresses beyond the bank read as zero.
    always_ff @(posedge rd_clk_i) begin
        if (rd_addr_i <= LAST_ADDR) begin
            rd_data_q <= mem_q[rd_addr_i];
        end else begin
            rd_data_q <= '0;
        end
    end

    // Gated write port.
    always_ff @(posedge wr_clk_i) begin
        if (wr_en_i && (wr_addr_i <= LAST_ADDR)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fb_pingpong.sv
// Double-buffered frame store: the writer fills the back bank, the display
// scans the front bank, and banks swap only at a display frame boundary.
module fb_pingpong
    import fb_pingpong_pkg::*;
#(
    parameter int ADDR_WIDTH  = FB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = FB_DATA_WIDTH,
    parameter int NUM_WORDS   = FB_NUM_WORDS,
    parameter int SYNC_STAGES = FB_SYNC_STAGES
) (
    input  logic                  rd_clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_frame_start,
    output logic                  front_bank,
    input  logic                  wr_clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_frame_toggle,
    output logic                  wr_ready
);

    logic [SYNC_STAGES-1:0]      tog_sync_q = '0;
    logic                        tog_hist_q;
    logic                        tog_edge_s;
    swap_state_e                 state_q;
    swap_state_e                 state_d;
    logic                        swap_s;
    logic                        front_q;
    logic                        ack_q;
    logic                        sel_q;
    logic                        valid_q;
    logic [SYNC_STAGES-1:0][1:0] wr_sync_q = '0;
    logic                        wr_front_s;
    logic                        wr_ready_s;
    logic [DATA_WIDTH-1:0]       rd_data0_s;
    logic [DATA_WIDTH-1:0]       rd_data1_s;

    // Bring the writer's frame toggle into the display domain.
    always_ff @(posedge rd_clk) begin
        tog_sync_q <= {tog_sync_q[SYNC_STAGES-2:0], wr_frame_toggle};
    end

    assign tog_edge_s = tog_sync_q[SYNC_STAGES-1] ^ tog_hist_q;

    // Swap state register.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            state_q <= SWAP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: an edge coinciding with a frame start swaps without pending.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SWAP_IDLE: begin
                if (tog_edge_s && !rd_frame_start) begin
                    state_d = SWAP_PENDING;
                end else begin
                    state_d = SWAP_IDLE;
                end
            end
            SWAP_PENDING: begin
                if (rd_frame_start) begin
                    state_d = SWAP_IDLE;
                end else begin
                    state_d = SWAP_PENDING;
                end
            end
            default: state_d = SWAP_IDLE;
        endcase
    end

    // Swap strobe.
    always_comb begin
        swap_s = 1'b0;
        case (state_q)
            SWAP_IDLE:    swap_s = rd_frame_start & tog_edge_s;
            SWAP_PENDING: swap_s = rd_frame_start;
            default:      swap_s = 1'b0;
        endcase
    end

    // Bank ownership and handshake ack; reset adopts the current toggle so
    // an interrupted handshake cannot leave the writer stalled.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            front_q    <= 1'b0;
            ack_q      <= tog_sync_q[SYNC_STAGES-1];
            tog_hist_q <= tog_sync_q[SYNC_STAGES-1];
            sel_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            tog_hist_q <= tog_sync_q[SYNC_STAGES-1];
            sel_q      <= front_q;
            valid_q    <= 1'b1;
            if (swap_s) begin
                front_q <= ~front_q;
                ack_q   <= ~ack_q;
            end else begin
                front_q <= front_q;
                ack_q   <= ack_q;
            end
        end
    end

    // Ack and front share one chain so the writer never sees them disagree.
    always_ff @(posedge wr_clk) begin
        wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], {ack_q, front_q}};
    end

    assign wr_ready_s = (wr_frame_toggle == wr_sync_q[SYNC_STAGES-1][1]);
    assign wr_front_s = wr_sync_q[SYNC_STAGES-1][0];

    fb_bank #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WORDS  (NUM_WORDS)
    ) u_bank0 (
        .rd_clk_i  (rd_clk),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data0_s),
        .wr_clk_i  (wr_clk),
        .wr_en_i   (wr_en & wr_ready_s & wr_front_s),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data)
    );

    fb_bank #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WORDS  (NUM_WORDS)
    ) u_bank1 (
        .rd_clk_i  (rd_clk),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data1_s),
        .wr_clk_i  (wr_clk),
        .wr_en_i   (wr_en & wr_ready_s & ~wr_front_s),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data)
    );

    assign rd_data    = valid_q ? (sel_q ? rd_data1_s : rd_data0_s) : '0;
    assign front_bank = front_q;
    assign wr_ready   = wr_ready_s;

endmodule
